// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch.
// Imported by the controller and its key conditioners.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int MAX_TIME       = 359999;
  localparam int LED_MAX_POS    = 9;
  localparam int LED_W          = 10;
  localparam int DEFAULT_TIME_W = 19;

  function automatic logic [3:0] next_pos(input logic [3:0] pos);
    return (pos == 4'd0) ? 4'(LED_MAX_POS) : pos - 4'd1;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// One active-low key: 2-flop synchronizer, debounce, press pulse.
// Pulses only after the key has been seen released since reset.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          armed;
  logic [1:0]    vld;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      armed <= 1'b0;
      vld   <= 2'b00;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      vld   <= {vld[0], 1'b1};
      press <= 1'b0;
      // vld[1] means sync2 now holds a real post-reset sample
      if (vld[1] && sync2 && level)
        armed <= 1'b1;
      if (sync2 != level) begin
        if (cnt == DB_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2 & armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: key conditioning, IDLE/RUN/PAUSE FSM,
// lap-freeze display register and walking-LED run indicator.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int TIME_W          = DEFAULT_TIME_W,
  parameter int LED_STEP        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key3,
  input  logic              key2,
  input  logic              key1,
  input  logic              key0,
  input  logic [TIME_W-1:0] time_counter,
  output logic              count_en,
  output logic              counter_clear,
  output logic [TIME_W-1:0] time_display,
  output logic              counting,
  output logic              paused,
  output logic              frozen,
  output logic [LED_W-1:0]  led
);

  localparam int PW = (LED_STEP > 1) ? $clog2(LED_STEP) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(LED_STEP - 1);

  logic [3:0]    press;
  state_t        state;
  state_t        state_n;
  logic          frozen_n;
  logic          clear_n;
  logic [3:0]    led_pos;
  logic [PW-1:0] presc;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key3 (
    .clk(clk), .reset(reset), .key(key3), .press(press[3]));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
    .clk(clk), .reset(reset), .key(key2), .press(press[2]));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk(clk), .reset(reset), .key(key1), .press(press[1]));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk(clk), .reset(reset), .key(key0), .press(press[0]));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      frozen        <= 1'b0;
      counter_clear <= 1'b0;
    end else begin
      state         <= state_n;
      frozen        <= frozen_n;
      counter_clear <= clear_n;
    end
  end

  // start/stop wins over everything; unfreeze wins over freeze
  always_comb begin
    state_n  = state;
    frozen_n = frozen;
    clear_n  = 1'b0;
    if (press[3]) begin
      state_n  = (state == IDLE) ? RUN : IDLE;
      frozen_n = 1'b0;
      clear_n  = 1'b1;
    end else begin
      if (press[2]) begin
        unique case (state)
          RUN:     state_n = PAUSE;
          PAUSE:   state_n = RUN;
          default: state_n = state;
        endcase
      end
      if (press[0])
        frozen_n = 1'b0;
      else if (press[1] && state == RUN)
        frozen_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || counter_clear)
      time_display <= '0;
    else if (!frozen)
      time_display <= time_counter;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_pos <= 4'(LED_MAX_POS);
      presc   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          led_pos <= 4'(LED_MAX_POS);
          presc   <= '0;
        end
        RUN: begin
          if (presc == PRESC_LAST) begin
            presc   <= '0;
            led_pos <= next_pos(led_pos);
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          led_pos <= led_pos;
          presc   <= presc;
        end
      endcase
    end
  end

  assign count_en = (state == RUN);
  assign paused   = (state == PAUSE);
  assign counting = (state == RUN) || (state == PAUSE);
  assign led      = counting ? (LED_W'(1) << led_pos) : '0;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed self-checking bench for stopwatch_controller.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_controller;

  logic        clk;
  logic        reset;
  logic        key3, key2, key1, key0;
  logic [18:0] time_counter;
  logic        count_en, counter_clear;
  logic [18:0] time_display;
  logic        counting, paused, frozen;
  logic [9:0]  led;

  int checks;
  int errors;

  stopwatch_controller dut (
    .clk(clk), .reset(reset),
    .key3(key3), .key2(key2), .key1(key1), .key0(key0),
    .time_counter(time_counter),
    .count_en(count_en), .counter_clear(counter_clear),
    .time_display(time_display),
    .counting(counting), .paused(paused), .frozen(frozen),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
  endtask

  // low for 3 samples, then 2 more cycles: state has just updated
  task automatic start_run();
    key3 = 1'b0;
    tick(3);
    key3 = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    key3 = 1'b1; key2 = 1'b1; key1 = 1'b1; key0 = 1'b1;
    time_counter = 19'd55;
    reset = 1'b1;
    tick(2);
    checks++;
    if ({counting, paused, count_en, counter_clear, frozen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {counting, paused, count_en, counter_clear, frozen});
    end
    checks++;
    if (time_display !== 19'd0) begin
      errors++;
      $display("FAIL reset_display: got %0d want 0", time_display);
    end
    checks++;
    if (led !== 10'h000) begin
      errors++;
      $display("FAIL reset_led: got %b want 0", led);
    end
    reset = 1'b0;
    tick(4);
    checks++;
    if (time_display !== 19'd55) begin
      errors++;
      $display("FAIL idle_track: got %0d want 55", time_display);
    end
  endtask

  task automatic test_start_stop();
    int pulses;
    pulses = 0;
    time_counter = 19'd0;
    key3 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (i == 5) key3 = 1'b1;
      if (counter_clear === 1'b1) pulses++;
      if (i == 5) begin
        checks++;
        if ({counting, paused, count_en, counter_clear} !== 4'b1011) begin
          errors++;
          $display("FAIL start_flags: got %b want 1011",
                   {counting, paused, count_en, counter_clear});
        end
        checks++;
        if (led !== 10'b1000000000) begin
          errors++;
          $display("FAIL start_led: got %b want 1000000000", led);
        end
      end
      if (i == 6) begin
        checks++;
        if ({count_en, counter_clear} !== 2'b10) begin
          errors++;
          $display("FAIL start_after_clear: got %b want 10",
                   {count_en, counter_clear});
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL start_one_clear: got %0d want 1", pulses);
    end
    start_run();
    checks++;
    if ({counting, count_en, counter_clear} !== 3'b001) begin
      errors++;
      $display("FAIL stop_flags: got %b want 001",
               {counting, count_en, counter_clear});
    end
    checks++;
    if (led !== 10'h000) begin
      errors++;
      $display("FAIL stop_led: got %b want 0", led);
    end
    tick(1);
  endtask

  task automatic test_glitch();
    apply_reset();
    start_run();
    tick(1);
    key2 = 1'b0;
    tick(1);
    key2 = 1'b1;
    tick(8);
    checks++;
    if ({counting, paused, count_en} !== 3'b101) begin
      errors++;
      $display("FAIL glitch_ignored: got %b want 101",
               {counting, paused, count_en});
    end
    key2 = 1'b0;
    tick(4);
    key2 = 1'b1;
    tick(1);
    checks++;
    if ({counting, paused, count_en} !== 3'b110) begin
      errors++;
      $display("FAIL glitch_pause: got %b want 110",
               {counting, paused, count_en});
    end
    tick(20);
    checks++;
    if (led !== 10'h100 || paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_led_hold: got %b/%b want 0100000000/1",
               led, paused);
    end
  endtask

  task automatic test_freeze();
    apply_reset();
    start_run();
    time_counter = 19'd1234;
    tick(2);
    key1 = 1'b0; tick(3); key1 = 1'b1; tick(2);
    checks++;
    if (frozen !== 1'b1 || time_display !== 19'd1234) begin
      errors++;
      $display("FAIL freeze_set: got %b/%0d want 1/1234",
               frozen, time_display);
    end
    time_counter = 19'd1235;
    tick(1);
    time_counter = 19'd1300;
    tick(3);
    checks++;
    if (time_display !== 19'd1234 || count_en !== 1'b1) begin
      errors++;
      $display("FAIL freeze_hold: got %0d/%b want 1234/1",
               time_display, count_en);
    end
    key0 = 1'b0; tick(3); key0 = 1'b1; tick(2);
    checks++;
    if (frozen !== 1'b0 || time_display !== 19'd1234) begin
      errors++;
      $display("FAIL unfreeze_edge: got %b/%0d want 0/1234",
               frozen, time_display);
    end
    tick(1);
    checks++;
    if (time_display !== 19'd1300) begin
      errors++;
      $display("FAIL unfreeze_track: got %0d want 1300", time_display);
    end
    time_counter = 19'd1301;
    tick(1);
    key1 = 1'b0; tick(3); key1 = 1'b1; tick(2);
    time_counter = 19'd1400;
    start_run();
    checks++;
    if ({frozen, counting, counter_clear} !== 3'b001 ||
        time_display !== 19'd1301) begin
      errors++;
      $display("FAIL stop_frozen: got %b/%0d want 001/1301",
               {frozen, counting, counter_clear}, time_display);
    end
    tick(1);
    checks++;
    if (time_display !== 19'd0) begin
      errors++;
      $display("FAIL clear_display: got %0d want 0", time_display);
    end
    tick(1);
    checks++;
    if (time_display !== 19'd1400) begin
      errors++;
      $display("FAIL post_clear_track: got %0d want 1400", time_display);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    start_run();
    tick(2);
    key3 = 1'b0; key2 = 1'b0; tick(3);
    key3 = 1'b1; key2 = 1'b1; tick(2);
    checks++;
    if ({counting, paused, count_en, counter_clear} !== 4'b0001) begin
      errors++;
      $display("FAIL k3_over_k2: got %b want 0001",
               {counting, paused, count_en, counter_clear});
    end
    tick(1);
    key1 = 1'b0; tick(3); key1 = 1'b1; tick(2);
    checks++;
    if (frozen !== 1'b0) begin
      errors++;
      $display("FAIL k1_idle_ignored: got %b want 0", frozen);
    end
    start_run();
    tick(2);
    key1 = 1'b0; key0 = 1'b0; tick(3);
    key1 = 1'b1; key0 = 1'b1; tick(2);
    checks++;
    if (frozen !== 1'b0 || count_en !== 1'b1) begin
      errors++;
      $display("FAIL k0_over_k1: got %b/%b want 0/1", frozen, count_en);
    end
    key1 = 1'b0; tick(3); key1 = 1'b1; tick(2);
    checks++;
    if (frozen !== 1'b1) begin
      errors++;
      $display("FAIL k1_run_sets: got %b want 1", frozen);
    end
  endtask

  task automatic test_led_wrap();
    apply_reset();
    start_run();
    tick(9);
    checks++;
    if (led !== 10'h200) begin
      errors++;
      $display("FAIL led_c9: got %b want 1000000000", led);
    end
    tick(1);
    checks++;
    if (led !== 10'h100) begin
      errors++;
      $display("FAIL led_c10: got %b want 0100000000", led);
    end
    tick(80);
    checks++;
    if (led !== 10'h001) begin
      errors++;
      $display("FAIL led_c90: got %b want 0000000001", led);
    end
    tick(10);
    checks++;
    if (led !== 10'h200) begin
      errors++;
      $display("FAIL led_wrap: got %b want 1000000000", led);
    end
    tick(20);
    key2 = 1'b0; tick(3); key2 = 1'b1; tick(2);
    tick(30);
    checks++;
    if (led !== 10'h080 || paused !== 1'b1) begin
      errors++;
      $display("FAIL led_pause_hold: got %b/%b want 0010000000/1",
               led, paused);
    end
    key2 = 1'b0; tick(3); key2 = 1'b1; tick(2);
    tick(4);
    checks++;
    if (led !== 10'h080 || count_en !== 1'b1) begin
      errors++;
      $display("FAIL led_resume_pos: got %b/%b want 0010000000/1",
               led, count_en);
    end
    tick(1);
    checks++;
    if (led !== 10'h040) begin
      errors++;
      $display("FAIL led_resume_step: got %b want 0001000000", led);
    end
  endtask

  task automatic test_reset_mid_press();
    int bad;
    bad = 0;
    key3 = 1'b0;
    tick(1);
    reset = 1'b1;
    time_counter = 19'd777;
    tick(3);
    checks++;
    if ({counting, paused, count_en, counter_clear, frozen} !== 5'b0 ||
        time_display !== 19'd0 || led !== 10'h000) begin
      errors++;
      $display("FAIL midpress_reset_vals: got %b/%0d/%b want 00000/0/0",
               {counting, paused, count_en, counter_clear, frozen},
               time_display, led);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (counter_clear !== 1'b0 || counting !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midpress_no_pulse: got %0d bad cycles want 0", bad);
    end
    key3 = 1'b1;
    tick(5);
    start_run();
    checks++;
    if ({counting, counter_clear} !== 2'b11) begin
      errors++;
      $display("FAIL midpress_repress: got %b want 11",
               {counting, counter_clear});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    key3 = 1'b1; key2 = 1'b1; key1 = 1'b1; key0 = 1'b1;
    time_counter = '0;
    test_reset();
    test_start_stop();
    test_glitch();
    test_freeze();
    test_simultaneous();
    test_led_wrap();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
